// File: rtl/reg_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one clocked write port.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module reg_file #(
    parameter logic [31:0] GP_INIT = 32'h0000_1800,
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RegWrite,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);

    logic [31:0] regs [0:31];
    logic        wr_en;
    logic [31:0] stored1;
    logic [31:0] stored2;

    // $0 is never written, so its entry keeps the reset value of zero.
    assign wr_en = RegWrite && (WriteReg != 5'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[28] <= GP_INIT;
            regs[29] <= SP_INIT;
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (ReadReg1 != 5'd0) begin
            stored1 = regs[ReadReg1];
        end
        if (ReadReg2 != 5'd0) begin
            stored2 = regs[ReadReg2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Writeback value forwarded to decode in the same cycle; suppressed while in reset.
    logic byp1;
    logic byp2;

    assign byp1 = wr_en && !Reset && (WriteReg == ReadReg1);
    assign byp2 = wr_en && !Reset && (WriteReg == ReadReg2);

    assign ReadData1 = byp1 ? WriteData : stored1;
    assign ReadData2 = byp2 ? WriteData : stored2;
`else
    assign ReadData1 = stored1;
    assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand sequences for reset and
// same-cycle corners, and randomized traffic against an array-based reference model.
module tb_reg_file;

    localparam logic [31:0] GP_INIT = 32'h0000_1800;
    localparam logic [31:0] SP_INIT = 32'h0000_3FFC;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int errors = 0;

    reg_file #(.GP_INIT(GP_INIT), .SP_INIT(SP_INIT)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .RegWrite(RegWrite),
        .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    // clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // reference model: plain array of architectural register values
    logic [31:0] mdl [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl[28] = GP_INIT;
        mdl[29] = SP_INIT;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : mdl[a];
    endfunction

    // value a read port should show before the edge while a write is being presented
    function automatic logic [31:0] model_read_pre(input logic [4:0] a, input logic we,
                                                   input logic [4:0] wa, input logic [31:0] wd);
        if (BYPASS && we && wa != 5'd0 && wa == a) return wd;
        return model_read(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: present one write/read set after a falling edge, check before and after the rising edge
    task automatic do_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge Clk);
        RegWrite  = we;
        WriteReg  = wa;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
        #1;
        check({tag, "_pre1"}, ReadData1, model_read_pre(r1, we, wa, wd));
        check({tag, "_pre2"}, ReadData2, model_read_pre(r2, we, wa, wd));
        @(posedge Clk);
        if (we && wa != 5'd0) mdl[wa] = wd;
        #1;
        check({tag, "_post1"}, ReadData1, model_read(r1));
        check({tag, "_post2"}, ReadData2, model_read(r2));
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd9,  32'h0,         32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[3] = '{1'b0, 5'd10, 32'h1234_5678, 5'd10, 5'd28, 32'h0,         GP_INIT};
        vecs[4] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd29, 32'h8000_0001, SP_INIT};
        vecs[5] = '{1'b1, 5'd28, 32'h0000_CAFE, 5'd28, 5'd8,  32'h0000_CAFE, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 5'd1,  32'h0,         5'd1,  5'd31, 32'h0,         32'h8000_0001};
        vecs[7] = '{1'b1, 5'd12, 32'h1,         5'd12, 5'd0,  32'h1,         32'h0};

        Reset = 1'b1;
        RegWrite = 1'b0;
        WriteReg = 5'd0;
        WriteData = 32'h0;
        ReadReg1 = 5'd28;
        ReadReg2 = 5'd29;
        model_reset();

        // reset contents visible before any clock edge
        #1;
        check("rst_gp", ReadData1, GP_INIT);
        check("rst_sp", ReadData2, SP_INIT);
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd0;
        #1;
        check("rst_r5", ReadData1, 32'h0);
        check("rst_r0", ReadData2, 32'h0);

        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // directed vector table: expectations written out by hand
        foreach (vecs[i]) begin
            @(negedge Clk);
            RegWrite  = vecs[i].we;
            WriteReg  = vecs[i].wa;
            WriteData = vecs[i].wd;
            ReadReg1  = vecs[i].r1;
            ReadReg2  = vecs[i].r2;
            @(posedge Clk);
            if (vecs[i].we && vecs[i].wa != 5'd0) mdl[vecs[i].wa] = vecs[i].wd;
            #1;
            check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
        end

        // same-cycle read/write of reg 12: old 1, new 2
        @(negedge Clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd12;
        WriteData = 32'h2;
        ReadReg1  = 5'd12;
        ReadReg2  = 5'd12;
        #1;
        check("same_pre1", ReadData1, BYPASS ? 32'h2 : 32'h1);
        check("same_pre2", ReadData2, BYPASS ? 32'h2 : 32'h1);
        @(posedge Clk);
        mdl[12] = 32'h2;
        #1;
        check("same_post1", ReadData1, 32'h2);

        // reset mid-operation with a write pending
        do_cycle(1'b1, 5'd29, 32'hA5A5_A5A5, 5'd29, 5'd3, "w29");
        @(negedge Clk);
        RegWrite  = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'h7777_7777;
        ReadReg1  = 5'd29;
        ReadReg2  = 5'd3;
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        check("midrst_sp", ReadData1, SP_INIT);
        check("midrst_r3", ReadData2, 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        RegWrite = 1'b0;
        #1;
        check("midrst_sp_after", ReadData1, SP_INIT);
        check("midrst_r3_after", ReadData2, 32'h0);
        ReadReg1 = 5'd12;
        #1;
        check("midrst_r12_cleared", ReadData1, 32'h0);

        // randomized traffic, biased toward address collisions
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [4:0]  wa, r1, r2;
            logic [31:0] wd;
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            do_cycle(we, wa, wd, r1, r2, "rnd");
        end

        // sweep every register through both ports
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            @(negedge Clk);
            ReadReg1 = 5'(a);
            ReadReg2 = 5'(31 - a);
            #1;
            check($sformatf("sweep1_%0d", a), ReadData1, model_read(5'(a)));
            check($sformatf("sweep2_%0d", a), ReadData2, model_read(5'(31 - a)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time limit so the bench always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
